// File: rtl/chacha_pkg.sv
// Shared constants, state encoding and quarter-round index tables for the
// ChaCha block engine and its quarter-round datapath.
package chacha_pkg;

  localparam int WORD_W      = 32;
  localparam int STATE_WORDS = 16;

  localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
  localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
  localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
  localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Row q holds the (a,b,c,d) state-word indices fed to quarter-round q.
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] v,
                                               input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha_quarterround.sv
// Combinational ChaCha quarter-round: four add/xor/rotate stages on a,b,c,d.
module chacha_quarterround
  import chacha_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic [WORD_W-1:0] c_i,
  input  logic [WORD_W-1:0] d_i,
  output logic [WORD_W-1:0] a_o,
  output logic [WORD_W-1:0] b_o,
  output logic [WORD_W-1:0] c_o,
  output logic [WORD_W-1:0] d_o
);

  logic [WORD_W-1:0] a1_s, b1_s, c1_s, d1_s;
  logic [WORD_W-1:0] a2_s, b2_s, c2_s, d2_s;

  assign a1_s = a_i + b_i;
  assign d1_s = rotl32(d_i ^ a1_s, 16);
  assign c1_s = c_i + d1_s;
  assign b1_s = rotl32(b_i ^ c1_s, 12);
  assign a2_s = a1_s + b1_s;
  assign d2_s = rotl32(d1_s ^ a2_s, 8);
  assign c2_s = c1_s + d2_s;
  assign b2_s = rotl32(b1_s ^ c2_s, 7);

  assign a_o = a2_s;
  assign b_o = b2_s;
  assign c_o = c2_s;
  assign d_o = d2_s;

endmodule

// File: rtl/chacha_block_engine.sv
// Iterative ChaCha block function: one column or diagonal round per cycle,
// then feed-forward add, then hold the keystream block until accepted.
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);

  localparam int               RND_W    = $clog2(ROUNDS);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  state_e                                state_q, state_d;
  logic [RND_W-1:0]                      rnd_q, rnd_d;
  logic [STATE_WORDS-1:0][WORD_W-1:0]    work_q, work_d;
  logic [STATE_WORDS-1:0][WORD_W-1:0]    init_q, init_d;
  logic [STATE_WORDS-1:0][WORD_W-1:0]    ks_q, ks_d;
  logic                                  out_valid_q, out_valid_d;
  logic [STATE_WORDS-1:0][WORD_W-1:0]    load_s, round_s;
  logic [3:0][3:0][WORD_W-1:0]           qr_in_s, qr_out_s;

  always_comb begin
    load_s     = '0;
    load_s[0]  = SIGMA0;
    load_s[1]  = SIGMA1;
    load_s[2]  = SIGMA2;
    load_s[3]  = SIGMA3;
    for (int i = 0; i < 8; i++) begin
      load_s[4+i] = key[32*i +: 32];
    end
    load_s[12] = counter;
    for (int j = 0; j < 3; j++) begin
      load_s[13+j] = nonce[32*j +: 32];
    end
  end

  // Even rounds work on columns, odd rounds on diagonals.
  always_comb begin
    qr_in_s = '0;
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < 4; k++) begin
        if (rnd_q[0]) begin
          qr_in_s[q][k] = work_q[DIAG_IDX[q][k]];
        end else begin
          qr_in_s[q][k] = work_q[COL_IDX[q][k]];
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_quarterround u_qr (
      .a_i (qr_in_s[g][0]),
      .b_i (qr_in_s[g][1]),
      .c_i (qr_in_s[g][2]),
      .d_i (qr_in_s[g][3]),
      .a_o (qr_out_s[g][0]),
      .b_o (qr_out_s[g][1]),
      .c_o (qr_out_s[g][2]),
      .d_o (qr_out_s[g][3])
    );
  end

  always_comb begin
    round_s = work_q;
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < 4; k++) begin
        if (rnd_q[0]) begin
          round_s[DIAG_IDX[q][k]] = qr_out_s[q][k];
        end else begin
          round_s[COL_IDX[q][k]] = qr_out_s[q][k];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    work_d      = work_q;
    init_d      = init_q;
    ks_d        = ks_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = load_s;
          init_d  = load_s;
          rnd_d   = '0;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        work_d = round_s;
        rnd_d  = rnd_q + RND_W'(1);
        if (rnd_q == LAST_RND) begin
          state_d = FINAL;
        end else begin
          state_d = ROUND;
        end
      end
      FINAL: begin
        for (int w = 0; w < STATE_WORDS; w++) begin
          work_d[w] = work_q[w] + init_q[w];
          ks_d[w]   = work_q[w] + init_q[w];
        end
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Reset drops any in-flight block so no partial result is ever presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      work_q      <= '0;
      init_q      <= '0;
      ks_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      work_q      <= work_d;
      init_q      <= init_d;
      ks_q        <= ks_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign keystream = ks_q;

endmodule

// File: tb/tb_chacha_block_engine.sv
// Directed bench for chacha_block_engine (ROUNDS=20 and ROUNDS=8) and the
// quarter-round sub-module, checked against RFC 8439 vectors and a reference model.
module tb_chacha_block_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic [511:0] keystream;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [511:0] keystream8;

  logic [31:0]  qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;

  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;
  logic [511:0] rfc_exp;
  logic [511:0] snap;
  int           vectors = 0;
  int           fails   = 0;
  int           n;

  localparam logic [31:0] RFC_W [16] = '{
    32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2
  };

  chacha_block_engine #(.ROUNDS(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .nonce(nonce), .counter(counter),
    .out_valid(out_valid), .out_ready(out_ready),
    .keystream(keystream), .busy(busy)
  );

  chacha_block_engine #(.ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .key(key), .nonce(nonce), .counter(counter),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .keystream(keystream8), .busy(busy8)
  );

  chacha_quarterround u_qr (
    .a_i(qa), .b_i(qb), .c_i(qc), .d_i(qd),
    .a_o(qa_o), .b_o(qb_o), .c_o(qc_o), .d_o(qd_o)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] qr_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] nn,
                                             input logic [31:0] cnt, input int rounds);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = cnt;
    for (int j = 0; j < 3; j++) s[13+j] = nn[32*j +: 32];
    x = s;
    for (int rr = 0; rr < rounds; rr += 2) begin
      {x[0], x[4], x[8],  x[12]} = qr_ref(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr_ref(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr_ref(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr_ref(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr_ref(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr_ref(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr_ref(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr_ref(x[3], x[4], x[9],  x[14]);
    end
    for (int w = 0; w < 16; w++) r[32*w +: 32] = x[w] + s[w];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin
      rfc_key[32*i +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    end
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    for (int w = 0; w < 16; w++) rfc_exp[32*w +: 32] = RFC_W[w];

    rst = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0; out_ready8 = 1'b0;
    key = '0; nonce = '0; counter = 32'h0;
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;

    // Quarter-round sub-module
    #1;
    check("qr_a", {480'h0, qa_o}, {480'h0, 32'hea2a92f4});
    check("qr_b", {480'h0, qb_o}, {480'h0, 32'hcb1cf8ce});
    check("qr_c", {480'h0, qc_o}, {480'h0, 32'h4581472e});
    check("qr_d", {480'h0, qd_o}, {480'h0, 32'h5881c4bb});

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_keystream", keystream, 512'h0);

    // Reset and in_valid together: reset wins
    rst = 1'b1; in_valid = 1'b1; key = rfc_key;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_valid_busy", busy, 1'b0);
    check("rst_vs_valid_ready", in_ready, 1'b1);

    // RFC 8439 2.3.2 block, latency, then backpressure
    key = rfc_key; nonce = rfc_nonce; counter = 32'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rfc_busy", busy, 1'b1);
    check("rfc_in_ready_low", in_ready, 1'b0);
    n = 1;
    while (!out_valid && n < 60) begin tick(); n++; end
    check("rfc_latency", 512'(n), 512'(22));
    check("rfc_keystream", keystream, rfc_exp);
    in_valid = 1'b1; key = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_keystream", keystream, rfc_exp);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_valid", out_valid, 1'b0);
    check("release_busy", busy, 1'b0);

    // All-zero tuple; stray in_valid at cycles 5 and 21; early out_ready
    key = '0; nonce = '0; counter = 32'h0; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    key = '1; counter = 32'hdeadbeef; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_mid", busy, 1'b1);
    check("early_ready_no_valid", out_valid, 1'b0);
    repeat (15) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("zero_valid_c22", out_valid, 1'b1);
    check("zero_word0", {480'h0, keystream[31:0]}, {480'h0, 32'hade0b876});
    check("zero_word1", {480'h0, keystream[63:32]}, {480'h0, 32'h903df1a0});
    check("zero_block", keystream, ref_block(256'h0, 96'h0, 32'h0, 20));
    tick();
    out_ready = 1'b0;
    check("zero_done_valid", out_valid, 1'b0);
    check("zero_done_ready", in_ready, 1'b1);

    // Reset at cycle 10, then a fresh block
    key = rfc_key; nonce = rfc_nonce; counter = 32'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_keystream", keystream, 512'h0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    repeat (25) tick();
    check("abort_no_partial", out_valid, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin tick(); n++; end
    check("reaccept_latency", 512'(n), 512'(22));
    check("reaccept_block", keystream, rfc_exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Counter 0xffffffff used as-is
    counter = 32'hffffffff; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin tick(); n++; end
    check("wrap_block", keystream, ref_block(rfc_key, rfc_nonce, 32'hffffffff, 20));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ChaCha8 variant on the all-zero tuple
    key = '0; nonce = '0; counter = 32'h0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 60) begin tick(); n++; end
    check("c8_latency", 512'(n), 512'(10));
    check("c8_block", keystream8, ref_block(256'h0, 96'h0, 32'h0, 8));
    check("c8_word0", {480'h0, keystream8[31:0]}, {480'h0, 32'h2fef003e});
    check("c8_word1", {480'h0, keystream8[63:32]}, {480'h0, 32'hd6405f89});
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("c8_done_valid", out_valid8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
